// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared widths, generation states and requester tags for the frame-buffer scheduler.
package fb_pkg;
   localparam int FB_AW = 16;
   localparam int FB_DW = 20;

   typedef enum logic [1:0] {
      G_IDLE  = 2'd0,
      G_START = 2'd1,
      G_RUN   = 2'd2
   } gen_state_t;

   typedef enum logic {
      OWN_HOST = 1'b0,
      OWN_ENG  = 1'b1
   } owner_t;
endpackage

// File: rtl/fb_rd_tag_pipe.sv
// rtl/fb_rd_tag_pipe.sv - delays a read-issue tag so it lines up with the returning port-A read data.
module fb_rd_tag_pipe
   import fb_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   push_i,
   input  owner_t owner_i,
   output logic   vld_o,
   output owner_t owner_o
);

   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] own_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         own_q <= '0;
      end else begin
         vld_q[0] <= push_i;
         own_q[0] <= owner_i;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            own_q[i] <= own_q[i-1];
         end
      end
   end

   assign vld_o   = vld_q[DEPTH-1];
   assign owner_o = owner_t'(own_q[DEPTH-1]);

endmodule

// File: rtl/fb_port_scheduler.sv
// rtl/fb_port_scheduler.sv - per-frame generation launcher plus round-robin host/engine arbiter for frame-buffer port A.
module fb_port_scheduler
   import fb_pkg::*;
#(
   parameter int RD_LATENCY = 2,
   parameter int AW         = FB_AW,
   parameter int DW         = FB_DW
) (
   input  logic          clk108,
   input  logic          reset_n,
   input  logic          frame_done,
   input  logic          gen_enable,
   output logic          gen_start,
   input  logic          eng_done,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   input  logic          eng_req,
   input  logic          eng_we,
   input  logic [AW-1:0] eng_addr,
   input  logic [DW-1:0] eng_wdata,
   output logic          eng_gnt,
   output logic          host_rvalid,
   output logic          eng_rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_address_a,
   output logic [DW-1:0] mem_data_a,
   output logic          mem_wren_a,
   input  logic [DW-1:0] mem_q_a,
   output logic [15:0]   gen_count,
   output logic          gen_overrun
);

   gen_state_t    state_q, state_d;
   logic          frame_q, primed_q, frame_edge_q;
   logic [15:0]   gen_count_q, gen_count_d;
   logic          overrun_q, overrun_d;
   owner_t        last_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic          wren_q;

   logic          eng_ok, xfer, sel_we;
   owner_t        sel_owner;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          tag_vld;
   owner_t        tag_owner;

   // primed_q keeps a frame_done level already high at reset release from counting as an edge
   always_ff @(posedge clk108 or negedge reset_n) begin
      if (!reset_n) begin
         frame_q      <= 1'b0;
         primed_q     <= 1'b0;
         frame_edge_q <= 1'b0;
      end else begin
         frame_q      <= frame_done;
         primed_q     <= 1'b1;
         frame_edge_q <= frame_done & ~frame_q & primed_q;
      end
   end

   always_ff @(posedge clk108 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= G_IDLE;
         gen_count_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         gen_count_q <= gen_count_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gen_count_d = gen_count_q;
      overrun_d   = overrun_q;
      gen_start   = 1'b0;
      unique case (state_q)
         G_IDLE: begin
            if (frame_edge_q && gen_enable) state_d = G_START;
         end
         G_START: begin
            gen_start = 1'b1;
            state_d   = G_RUN;
         end
         G_RUN: begin
            if (eng_done) begin
               gen_count_d = gen_count_q + 16'd1;
               state_d     = (frame_edge_q && gen_enable) ? G_START : G_IDLE;
            end else if (frame_edge_q) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = G_IDLE;
      endcase
   end

   // on a tie the side that did not win last time gets the port
   assign eng_ok   = (state_q == G_RUN);
   assign host_gnt = host_req && !(eng_req && eng_ok && (last_q == OWN_HOST));
   assign eng_gnt  = eng_req && eng_ok && !(host_req && (last_q == OWN_ENG));

   assign xfer      = host_gnt | eng_gnt;
   assign sel_owner = eng_gnt ? OWN_ENG : OWN_HOST;
   assign sel_we    = eng_gnt ? eng_we    : host_we;
   assign sel_addr  = eng_gnt ? eng_addr  : host_addr;
   assign sel_wdata = eng_gnt ? eng_wdata : host_wdata;

   always_ff @(posedge clk108 or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= OWN_ENG;
         addr_q <= '0;
         data_q <= '0;
         wren_q <= 1'b0;
      end else begin
         wren_q <= xfer & sel_we;
         if (xfer) begin
            last_q <= sel_owner;
            addr_q <= sel_addr;
         end
         if (xfer && sel_we) data_q <= sel_wdata;
      end
   end

   fb_rd_tag_pipe #(
      .DEPTH (1 + RD_LATENCY)
   ) u_rd_tag_pipe (
      .clk_i   (clk108),
      .rst_ni  (reset_n),
      .push_i  (xfer & ~sel_we),
      .owner_i (sel_owner),
      .vld_o   (tag_vld),
      .owner_o (tag_owner)
   );

   assign host_rvalid   = tag_vld && (tag_owner == OWN_HOST);
   assign eng_rvalid    = tag_vld && (tag_owner == OWN_ENG);
   assign rdata         = tag_vld ? mem_q_a : '0;
   assign mem_address_a = addr_q;
   assign mem_data_a    = data_q;
   assign mem_wren_a    = wren_q;
   assign gen_count     = gen_count_q;
   assign gen_overrun   = overrun_q;

endmodule

// File: tb/tb_fb_port_scheduler.sv
// tb/tb_fb_port_scheduler.sv - self-checking bench for fb_port_scheduler with a frame-buffer memory model.
module tb_fb_port_scheduler;
   import fb_pkg::*;

   localparam int RDL = 2;
   localparam int AW  = 16;
   localparam int DW  = 20;

   logic          clk108 = 1'b0;
   logic          reset_n, frame_done, gen_enable, gen_start, eng_done;
   logic          host_req, host_we, host_gnt, eng_req, eng_we, eng_gnt;
   logic [AW-1:0] host_addr, eng_addr, mem_address_a;
   logic [DW-1:0] host_wdata, eng_wdata, rdata, mem_data_a, mem_q_a, rd1;
   logic          host_rvalid, eng_rvalid, mem_wren_a, gen_overrun;
   logic [15:0]   gen_count;

   logic [DW-1:0] mem_arr [0:65535];
   logic [DW-1:0] shadow  [0:65535];

   typedef struct {
      int            due;
      bit            eng;
      logic [DW-1:0] data;
   } rd_exp_t;
   rd_exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk108 = ~clk108;

   fb_port_scheduler #(.RD_LATENCY(RDL), .AW(AW), .DW(DW)) dut (
      .clk108(clk108), .reset_n(reset_n), .frame_done(frame_done), .gen_enable(gen_enable),
      .gen_start(gen_start), .eng_done(eng_done),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt),
      .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
      .eng_gnt(eng_gnt),
      .host_rvalid(host_rvalid), .eng_rvalid(eng_rvalid), .rdata(rdata),
      .mem_address_a(mem_address_a), .mem_data_a(mem_data_a), .mem_wren_a(mem_wren_a),
      .mem_q_a(mem_q_a), .gen_count(gen_count), .gen_overrun(gen_overrun)
   );

   // synchronous RAM with two-cycle read latency from the registered address
   always @(posedge clk108) begin
      if (mem_wren_a) mem_arr[mem_address_a] <= mem_data_a;
      rd1     <= mem_arr[mem_address_a];
      mem_q_a <= rd1;
   end

   function automatic logic [DW-1:0] dflt(input int a);
      logic [15:0] a16;
      a16 = a[15:0];
      return {a16[3:0], a16} ^ 20'h5A5A5;
   endfunction

   task automatic tick();
      @(posedge clk108);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; frame_done = 1'b0; gen_enable = 1'b0; eng_done = 1'b0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic enter_run();
      gen_enable = 1'b1;
      frame_done = 1'b0;
      tick();
      frame_done = 1'b1;
      tick(); tick(); tick();
      frame_done = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({gen_start, host_gnt, eng_gnt, host_rvalid, eng_rvalid, rdata, mem_address_a,
           mem_data_a, mem_wren_a, gen_count, gen_overrun} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got gen_count=%h wren=%b addr=%h rvalid=%b%b expected all 0",
                  gen_count, mem_wren_a, mem_address_a, host_rvalid, eng_rvalid);
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_generation();
      logic [3:0] starts;
      do_reset();
      gen_enable = 1'b1;
      tick();
      frame_done = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         starts[k] = gen_start;
      end
      n_tests++;
      if (starts !== 4'b0010) begin
         n_fail++;
         $display("FAIL gen_start_timing: got %b expected 0010 (cycles +1..+4)", starts);
      end
      eng_req = 1'b1; #1;
      n_tests++;
      if (eng_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL eng_gnt_run: got %b expected 1", eng_gnt);
      end
      eng_req = 1'b0; frame_done = 1'b0; eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      n_tests++;
      if (gen_count !== 16'd1) begin
         n_fail++;
         $display("FAIL gen_count_one: got %h expected 0001", gen_count);
      end
      eng_req = 1'b1; #1;
      n_tests++;
      if (eng_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL eng_gnt_after_done: got %b expected 0", eng_gnt);
      end
      eng_req = 1'b0;
   endtask

   task automatic test_alternation();
      logic [5:0]    pat;
      bit            last_eng;
      logic [AW-1:0] exp_a;
      logic [DW-1:0] exp_d;
      int            writes;
      do_reset();
      enter_run();
      tick();
      last_eng = 1'b1;
      writes = 0;
      host_req = 1'b1; host_we = 1'b1; eng_req = 1'b1; eng_we = 1'b1;
      host_addr = 16'($urandom); host_wdata = 20'($urandom);
      eng_addr  = 16'($urandom); eng_wdata  = 20'($urandom);
      for (int k = 0; k < 6; k++) begin
         #1;
         pat[5-k] = host_gnt;
         n_tests++;
         if ({host_gnt, eng_gnt} !== {last_eng, !last_eng}) begin
            n_fail++;
            $display("FAIL alt_grant_%0d: got h=%b e=%b expected h=%b e=%b",
                     k, host_gnt, eng_gnt, last_eng, !last_eng);
         end
         exp_a = last_eng ? host_addr : eng_addr;
         exp_d = last_eng ? host_wdata : eng_wdata;
         last_eng = !last_eng;
         tick();
         if (k == 5) begin host_req = 1'b0; eng_req = 1'b0; end
         n_tests++;
         if ({mem_wren_a, mem_address_a, mem_data_a} !== {1'b1, exp_a, exp_d}) begin
            n_fail++;
            $display("FAIL alt_porta_%0d: got wren=%b a=%h d=%h expected 1 a=%h d=%h",
                     k, mem_wren_a, mem_address_a, mem_data_a, exp_a, exp_d);
         end
         writes += int'(mem_wren_a);
         if (!last_eng) begin host_addr = 16'($urandom); host_wdata = 20'($urandom); end
         else begin eng_addr = 16'($urandom); eng_wdata = 20'($urandom); end
      end
      tick();
      writes += int'(mem_wren_a);
      n_tests++;
      if (pat !== 6'b101010 || writes != 6) begin
         n_fail++;
         $display("FAIL alt_pattern: got %b writes=%0d expected 101010 writes=6", pat, writes);
      end
   endtask

   task automatic test_host_read();
      logic [5:1] hv, ev;
      logic [DW-1:0] d3;
      do_reset();
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 20'hABCDE;
      tick();
      shadow[16'h1234] = 20'hABCDE;
      host_req = 1'b0;
      tick(); tick();
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h1234;
      tick();
      host_req = 1'b0;
      d3 = '0;
      for (int k = 1; k <= 5; k++) begin
         hv[k] = host_rvalid;
         ev[k] = eng_rvalid;
         if (k == 3) d3 = rdata;
         if (k < 5) tick();
      end
      n_tests++;
      if (hv !== 5'b00100 || ev !== 5'b0) begin
         n_fail++;
         $display("FAIL host_read_timing: got host=%b eng=%b expected host=00100 eng=00000", hv, ev);
      end
      n_tests++;
      if (d3 !== 20'hABCDE) begin
         n_fail++;
         $display("FAIL host_read_data: got %h expected abcde", d3);
      end
   endtask

   task automatic test_overrun();
      int starts;
      do_reset();
      gen_enable = 1'b1;
      eng_req = 1'b1; #1;
      n_tests++;
      if (eng_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL eng_gnt_idle: got %b expected 0", eng_gnt);
      end
      eng_req = 1'b0;
      starts = 0;
      for (int k = 0; k < 10; k++) begin
         frame_done = (k < 2 || k == 4 || k == 5);
         #1;
         starts += int'(gen_start);
         tick();
      end
      frame_done = 1'b0;
      n_tests++;
      if (gen_overrun !== 1'b1 || starts != 1) begin
         n_fail++;
         $display("FAIL overrun: got overrun=%b starts=%0d expected overrun=1 starts=1", gen_overrun, starts);
      end
      gen_enable = 1'b0;
      eng_req = 1'b1; #1;
      n_tests++;
      if (eng_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL run_survives_disable: got %b expected 1", eng_gnt);
      end
      eng_req = 1'b0; eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      n_tests++;
      if (gen_count !== 16'd1 || gen_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_done: got count=%h overrun=%b expected 0001 1", gen_count, gen_overrun);
      end
   endtask

   task automatic test_reset_flush();
      int seen, starts;
      do_reset();
      gen_enable = 1'b1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0042;
      tick();
      host_req = 1'b0;
      tick();
      reset_n = 1'b0;
      frame_done = 1'b1;
      #1;
      n_tests++;
      if ({gen_start, host_gnt, eng_gnt, host_rvalid, eng_rvalid, rdata, mem_address_a,
           mem_data_a, mem_wren_a, gen_count, gen_overrun} !== '0) begin
         n_fail++;
         $display("FAIL flush_outputs: got addr=%h rvalid=%b%b count=%h expected all 0",
                  mem_address_a, host_rvalid, eng_rvalid, gen_count);
      end
      tick();
      reset_n = 1'b1;
      seen = 0; starts = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         seen += int'(host_rvalid | eng_rvalid);
         starts += int'(gen_start);
      end
      n_tests++;
      if (seen != 0 || starts != 0) begin
         n_fail++;
         $display("FAIL flush_quiet: got rvalids=%0d starts=%0d expected 0 0", seen, starts);
      end
      enter_run();
      host_req = 1'b1; eng_req = 1'b1; eng_we = 1'b0; #1;
      n_tests++;
      if ({host_gnt, eng_gnt} !== 2'b10) begin
         n_fail++;
         $display("FAIL first_tie: got h=%b e=%b expected h=1 e=0", host_gnt, eng_gnt);
      end
      host_req = 1'b0; eng_req = 1'b0;
      tick();
      repeat (4) tick();
   endtask

   task automatic test_wrap();
      do_reset();
      enter_run();
      dut.gen_count_q <= 16'hFFFF;
      tick();
      frame_done = 1'b1;
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0; frame_done = 1'b0;
      n_tests++;
      if (gen_count !== 16'h0000 || gen_start !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_relaunch: got count=%h start=%b expected 0000 1", gen_count, gen_start);
      end
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      n_tests++;
      if (gen_count !== 16'h0001) begin
         n_fail++;
         $display("FAIL wrap_next: got %h expected 0001", gen_count);
      end
   endtask

   task automatic test_random_traffic(input bit run, input int n);
      int            cc;
      bit            last_eng, h_pend, e_pend, win_h, win_e, exp_h, exp_e;
      bit            prev_x, prev_we;
      logic [AW-1:0] prev_a, ta;
      logic [DW-1:0] prev_d, exp_d;
      do_reset();
      if (run) enter_run(); else gen_enable = 1'b0;
      tick();
      cc = 0; last_eng = 1'b1; h_pend = 0; e_pend = 0; prev_x = 0; prev_we = 0;
      prev_a = '0; prev_d = '0;
      for (int i = 0; i < n + 5; i++) begin
         exp_h = 0; exp_e = 0; exp_d = '0;
         if (exp_q.size() > 0 && exp_q[0].due == cc) begin
            exp_h = !exp_q[0].eng; exp_e = exp_q[0].eng; exp_d = exp_q[0].data;
            void'(exp_q.pop_front());
         end
         n_tests++;
         if ({host_rvalid, eng_rvalid} !== {exp_h, exp_e} ||
             ((exp_h || exp_e) && rdata !== exp_d)) begin
            n_fail++;
            $display("FAIL rnd_rvalid c%0d: got h=%b e=%b d=%h expected h=%b e=%b d=%h",
                     cc, host_rvalid, eng_rvalid, rdata, exp_h, exp_e, exp_d);
         end
         n_tests++;
         if (mem_wren_a !== (prev_x && prev_we) ||
             (prev_x && (mem_address_a !== prev_a || (prev_we && mem_data_a !== prev_d)))) begin
            n_fail++;
            $display("FAIL rnd_porta c%0d: got wren=%b a=%h d=%h expected wren=%b a=%h d=%h",
                     cc, mem_wren_a, mem_address_a, mem_data_a, prev_x && prev_we, prev_a, prev_d);
         end
         if (i >= n) begin
            host_req = 1'b0; eng_req = 1'b0;
         end else begin
            if (!h_pend) begin
               host_req = 1'($urandom_range(0, 1)); host_we = 1'($urandom_range(0, 1));
               host_addr = 16'($urandom_range(0, 15)); host_wdata = 20'($urandom);
            end
            if (!e_pend) begin
               eng_req = 1'($urandom_range(0, 1)); eng_we = 1'($urandom_range(0, 1));
               eng_addr = 16'($urandom_range(0, 15)); eng_wdata = 20'($urandom);
            end
         end
         #1;
         win_e = eng_req && run && !(host_req && last_eng);
         win_h = host_req && !win_e;
         n_tests++;
         if ({host_gnt, eng_gnt} !== {win_h, win_e}) begin
            n_fail++;
            $display("FAIL rnd_grant c%0d: got h=%b e=%b expected h=%b e=%b",
                     cc, host_gnt, eng_gnt, win_h, win_e);
         end
         prev_x = win_h || win_e;
         if (prev_x) begin
            last_eng = win_e;
            prev_we  = win_e ? eng_we : host_we;
            ta       = win_e ? eng_addr : host_addr;
            prev_a   = ta;
            if (prev_we) begin
               prev_d = win_e ? eng_wdata : host_wdata;
               shadow[ta] = prev_d;
            end else begin
               exp_q.push_back('{cc + 1 + RDL, win_e, shadow[ta]});
            end
         end
         h_pend = host_req && !win_h;
         e_pend = eng_req && !win_e;
         tick();
         cc++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rnd_drain: got %0d reads outstanding expected 0", exp_q.size());
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem_arr[a] <= dflt(a);
         shadow[a]   = dflt(a);
      end
      test_reset();
      test_generation();
      test_alternation();
      test_host_read();
      test_overrun();
      test_reset_flush();
      test_wrap();
      test_random_traffic(1'b0, 60);
      test_random_traffic(1'b1, 300);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_port_scheduler.md
FB_PORT_SCHEDULER -- requirements
Module: fb_port_scheduler

Interface
REQ-001 Parameter RD_LATENCY, default 2: cycles from a read transfer to mem_q_a valid.
REQ-002 Parameter AW, default 16: frame-buffer word address width.
REQ-003 Parameter DW, default 20: frame-buffer word width, 20 pixels per word.
REQ-004 clk108  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 frame_done  in  1  display end-of-frame level (ready_sig); rising edge marks a frame boundary.
REQ-007 gen_enable  in  1  when high, one automaton generation is launched per frame.
REQ-008 gen_start  out  1  one-cycle pulse telling the engine to compute a generation.
REQ-009 eng_done  in  1  one-cycle pulse: engine finished current generation.
REQ-010 host_req / host_we  in  1 / 1  host port request, write when we=1.
REQ-011 host_addr / host_wdata  in  AW / DW  host address and write data; stable while host_req high.
REQ-012 host_gnt  out  1  transfer occurs on a cycle with host_req && host_gnt.
REQ-013 eng_req / eng_we / eng_addr / eng_wdata / eng_gnt  same as host, engine side.
REQ-014 host_rvalid / eng_rvalid  out  1  read data valid for that requester.
REQ-015 rdata  out  DW  read data, shared by both requesters.
REQ-016 mem_address_a / mem_data_a / mem_wren_a  out  AW / DW / 1  frame-buffer port A.
REQ-017 mem_q_a  in  DW  port A read data.
REQ-018 gen_count  out  16  completed generations; wraps 0xFFFF -> 0.
REQ-019 gen_overrun  out  1  sticky: a frame edge arrived while a generation was running.

Function
REQ-020 Generation FSM states SHALL be G_IDLE, G_START, G_RUN.
REQ-021 G_IDLE -> G_START on a frame_done rising edge with gen_enable=1; otherwise the FSM stays in G_IDLE.
REQ-022 G_START SHALL assert gen_start for exactly one cycle, then enter G_RUN.
REQ-023 G_RUN -> G_IDLE on eng_done; gen_count increments on the same edge.
REQ-024 A frame edge in G_RUN without eng_done SHALL set gen_overrun and SHALL NOT relaunch.
REQ-025 A frame edge and eng_done in the same G_RUN cycle SHALL count the generation and go directly to G_START when gen_enable=1.
REQ-026 eng_gnt SHALL be 0 outside G_RUN; the host is eligible in every state.
REQ-027 Eligible requests arbitrate round-robin: on a tie, the requester not granted last wins.
REQ-028 Grants SHALL be combinational from registered state and current requests; at most one gnt is high per cycle.
REQ-029 A single requester with req held high SHALL receive a transfer every cycle.
REQ-030 Port A outputs SHALL be registered: a transfer at cycle t drives address, data and wren at t+1.
REQ-031 mem_wren_a SHALL be 0 in every cycle without a write transfer; address and data hold their last values.
REQ-032 A read transfer at t SHALL raise the owner's rvalid at t+1+RD_LATENCY for one cycle, with rdata = mem_q_a.
REQ-033 Back-to-back reads from mixed owners SHALL return in issue order with correct owner tags.
REQ-034 gen_enable deasserted in G_RUN SHALL NOT abort the running generation.

Reset
REQ-035 reset_n low SHALL asynchronously clear all outputs and state to 0; FSM enters G_IDLE.
REQ-036 The last-winner pointer SHALL reset to engine, so the host wins the first tie.
REQ-037 Reset mid-operation SHALL flush in-flight read tags; no rvalid is issued after release for pre-reset reads.
REQ-038 The frame_done edge detector SHALL reset to 0; frame_done high at release SHALL NOT count as an edge.

Structure
REQ-039 Package fb_pkg SHALL hold FB_AW, FB_DW, the gen_state_t enum, and the owner_t {OWN_HOST, OWN_ENG} enum.
REQ-040 The read-return tag shift register SHALL be sub-module fb_rd_tag_pipe, with depth 1+RD_LATENCY.

Verification
REQ-041 gen_enable=1, frame_done rising edge -> gen_start pulses 2 cycles later; eng_done -> gen_count=1, FSM in G_IDLE.
REQ-042 Both requesters hold write requests in G_RUN for 6 cycles -> grants alternate H,E,H,E,H,E; 6 writes on port A, each one cycle after its grant.
REQ-043 Host read at addr 0x1234 with mem model returning 0xABCDE -> host_rvalid high exactly 3 cycles after the transfer, rdata=0xABCDE; eng_rvalid stays 0.
REQ-044 Two frame edges with no eng_done -> gen_overrun=1, a single gen_start; eng_req in G_IDLE -> eng_gnt=0.
REQ-045 Issue host read, assert reset_n low for 1 cycle, release -> no rvalid; all outputs 0; host wins the first tie.
REQ-046 gen_count=0xFFFF plus one eng_done -> gen_count=0x0000.
